// File: rtl/imm_decode_unit.sv
`default_nettype none
// ============================================================================
// Module      : imm_decode_unit
// Description : RISC-V immediate decoder behind a 2-entry skid buffer.
//               Decodes the immediate, format code and legality of an
//               instruction word at input transfer and presents the result
//               one cycle later, with full-throughput valid/ready handshakes.
// Revision    : 1.0 - initial release
// ============================================================================
module imm_decode_unit #(
  parameter int XLEN    = 32,
  parameter int SHAMT_W = (XLEN == 64) ? 6 : 5
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            flush_i,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [31:0]     data_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [XLEN-1:0] data_o,
  output logic [2:0]      fmt_o,
  output logic            illegal_o
);

  // Format codes presented on fmt_o
  localparam logic [2:0] FMT_R   = 3'd0;
  localparam logic [2:0] FMT_I   = 3'd1;
  localparam logic [2:0] FMT_S   = 3'd2;
  localparam logic [2:0] FMT_B   = 3'd3;
  localparam logic [2:0] FMT_U   = 3'd4;
  localparam logic [2:0] FMT_J   = 3'd5;
  localparam logic [2:0] FMT_ILL = 3'd7;

  // Major opcodes recognised by the decoder
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_IMM32  = 7'b0011011;

  // Word-sized shift instructions always carry a 5-bit shamt
  localparam int SHAMT_W32 = 5;

  // --------------------------------------------------------------------------
  // Combinational decode of the incoming word
  // --------------------------------------------------------------------------
  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic            is_shift;
  logic [31:0]     imm32;
  logic [XLEN-1:0] dec_imm;
  logic [2:0]      dec_fmt;
  logic            dec_ill;

  assign opcode   = data_i[6:0];
  assign funct3   = data_i[14:12];
  assign is_shift = (funct3 == 3'b001) || (funct3 == 3'b101);

  // Build a 32-bit sign-correct immediate; widening to XLEN happens below
  always_comb begin
    imm32   = 32'd0;
    dec_fmt = FMT_ILL;
    dec_ill = 1'b1;
    unique case (opcode)
      OP_LOAD, OP_JALR: begin
        imm32   = {{20{data_i[31]}}, data_i[31:20]};
        dec_fmt = FMT_I;
        dec_ill = 1'b0;
      end
      OP_IMM: begin
        // Shift-immediates carry a zero-extended shamt, not a signed value
        if (is_shift) begin
          imm32 = 32'(data_i[20 +: SHAMT_W]);
        end else begin
          imm32 = {{20{data_i[31]}}, data_i[31:20]};
        end
        dec_fmt = FMT_I;
        dec_ill = 1'b0;
      end
      OP_IMM32: begin
        // Word-immediate ops only exist on the 64-bit machine
        if (XLEN == 64) begin
          if (is_shift) begin
            imm32 = 32'(data_i[20 +: SHAMT_W32]);
          end else begin
            imm32 = {{20{data_i[31]}}, data_i[31:20]};
          end
          dec_fmt = FMT_I;
          dec_ill = 1'b0;
        end
      end
      OP_STORE: begin
        imm32   = {{20{data_i[31]}}, data_i[31:25], data_i[11:7]};
        dec_fmt = FMT_S;
        dec_ill = 1'b0;
      end
      OP_BRANCH: begin
        imm32   = {{19{data_i[31]}}, data_i[31], data_i[7],
                   data_i[30:25], data_i[11:8], 1'b0};
        dec_fmt = FMT_B;
        dec_ill = 1'b0;
      end
      OP_LUI, OP_AUIPC: begin
        imm32   = {data_i[31:12], 12'd0};
        dec_fmt = FMT_U;
        dec_ill = 1'b0;
      end
      OP_JAL: begin
        imm32   = {{11{data_i[31]}}, data_i[31], data_i[19:12],
                   data_i[20], data_i[30:21], 1'b0};
        dec_fmt = FMT_J;
        dec_ill = 1'b0;
      end
      OP_REG: begin
        imm32   = 32'd0;
        dec_fmt = FMT_R;
        dec_ill = 1'b0;
      end
      default: begin
        imm32   = 32'd0;
        dec_fmt = FMT_ILL;
        dec_ill = 1'b1;
      end
    endcase
  end

  // Every 32-bit immediate already holds its sign in bit 31, so widening
  // only needs to replicate that bit.
  generate
    if (XLEN > 32) begin : g_widen
      assign dec_imm = {{(XLEN-32){imm32[31]}}, imm32};
    end else begin : g_native
      assign dec_imm = imm32;
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Skid buffer: output register plus one skid entry
  // --------------------------------------------------------------------------
  logic            out_valid_q, out_valid_n;
  logic [XLEN-1:0] out_data_q,  out_data_n;
  logic [2:0]      out_fmt_q,   out_fmt_n;
  logic            out_ill_q,   out_ill_n;
  logic            skid_valid_q, skid_valid_n;
  logic [XLEN-1:0] skid_data_q,  skid_data_n;
  logic [2:0]      skid_fmt_q,   skid_fmt_n;
  logic            skid_ill_q,   skid_ill_n;
  logic            in_ready_q;
  logic            in_xfer;
  logic            out_free;

  assign in_xfer  = in_valid_i && in_ready_q;
  // The output register can take a new entry if it is empty or draining now
  assign out_free = !out_valid_q || out_ready_i;

  // Next-state steering: skid drains first to preserve order, otherwise the
  // new word goes to the output register, or to the skid when output stalls
  always_comb begin
    out_valid_n  = out_valid_q;
    out_data_n   = out_data_q;
    out_fmt_n    = out_fmt_q;
    out_ill_n    = out_ill_q;
    skid_valid_n = skid_valid_q;
    skid_data_n  = skid_data_q;
    skid_fmt_n   = skid_fmt_q;
    skid_ill_n   = skid_ill_q;

    if (out_free) begin
      if (skid_valid_q) begin
        // in_ready is low while the skid is full, so no new word arrives here
        out_valid_n  = 1'b1;
        out_data_n   = skid_data_q;
        out_fmt_n    = skid_fmt_q;
        out_ill_n    = skid_ill_q;
        skid_valid_n = 1'b0;
      end else if (in_xfer) begin
        out_valid_n = 1'b1;
        out_data_n  = dec_imm;
        out_fmt_n   = dec_fmt;
        out_ill_n   = dec_ill;
      end else begin
        out_valid_n = 1'b0;
      end
    end else if (in_xfer) begin
      skid_valid_n = 1'b1;
      skid_data_n  = dec_imm;
      skid_fmt_n   = dec_fmt;
      skid_ill_n   = dec_ill;
    end
  end

  // State register; reset and flush both empty the buffer, reset wins
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_fmt_q    <= FMT_R;
      out_ill_q    <= 1'b0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      skid_fmt_q   <= FMT_R;
      skid_ill_q   <= 1'b0;
      in_ready_q   <= 1'b1;
    end else begin
      out_valid_q  <= out_valid_n;
      out_data_q   <= out_data_n;
      out_fmt_q    <= out_fmt_n;
      out_ill_q    <= out_ill_n;
      skid_valid_q <= skid_valid_n;
      skid_data_q  <= skid_data_n;
      skid_fmt_q   <= skid_fmt_n;
      skid_ill_q   <= skid_ill_n;
      // Registered ready: accept whenever the skid will be free next cycle
      in_ready_q   <= !skid_valid_n;
    end
  end

  assign in_ready_o  = in_ready_q;
  assign out_valid_o = out_valid_q;
  assign data_o      = out_data_q;
  assign fmt_o       = out_fmt_q;
  assign illegal_o   = out_ill_q;

endmodule
`default_nettype wire

// File: tb/tb_imm_decode_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_imm_decode_unit
// Description : Directed self-checking bench for imm_decode_unit, driving a
//               32-bit and a 64-bit instance in lockstep.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_imm_decode_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] data_in = 32'd0;
  logic        out_ready = 1'b1;

  logic        rdy32, vld32, ill32;
  logic [31:0] dat32;
  logic [2:0]  fmt32;
  logic        rdy64, vld64, ill64;
  logic [63:0] dat64;
  logic [2:0]  fmt64;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  imm_decode_unit #(.XLEN(32)) dut32 (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .in_valid_i(in_valid), .in_ready_o(rdy32), .data_i(data_in),
    .out_valid_o(vld32), .out_ready_i(out_ready),
    .data_o(dat32), .fmt_o(fmt32), .illegal_o(ill32)
  );

  imm_decode_unit #(.XLEN(64)) dut64 (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .in_valid_i(in_valid), .in_ready_o(rdy64), .data_i(data_in),
    .out_valid_o(vld64), .out_ready_i(out_ready),
    .data_o(dat64), .fmt_o(fmt64), .illegal_o(ill64)
  );

  typedef struct {
    logic [31:0] ins;
    logic [63:0] e32; logic [2:0] f32; logic i32;
    logic [63:0] e64; logic [2:0] f64; logic i64;
  } vec_t;

  localparam int NV = 17;
  vec_t vecs [NV];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock edge; inputs are driven and outputs sampled on the falling edge
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_vld32"}, 64'(vld32), 64'd0);
    chk({tag, "_rdy32"}, 64'(rdy32), 64'd1);
    chk({tag, "_vld64"}, 64'(vld64), 64'd0);
    chk({tag, "_rdy64"}, 64'(rdy64), 64'd1);
  endtask

  initial begin
    vecs[0]  = '{32'hFFF00093, 64'hFFFFFFFF, 3'd1, 1'b0, 64'hFFFFFFFF_FFFFFFFF, 3'd1, 1'b0};
    vecs[1]  = '{32'h4030D093, 64'h00000003, 3'd1, 1'b0, 64'h00000000_00000003, 3'd1, 1'b0};
    vecs[2]  = '{32'hFE112E23, 64'hFFFFFFFC, 3'd2, 1'b0, 64'hFFFFFFFF_FFFFFFFC, 3'd2, 1'b0};
    vecs[3]  = '{32'hFE000CE3, 64'hFFFFFFF8, 3'd3, 1'b0, 64'hFFFFFFFF_FFFFFFF8, 3'd3, 1'b0};
    vecs[4]  = '{32'h123450B7, 64'h12345000, 3'd4, 1'b0, 64'h00000000_12345000, 3'd4, 1'b0};
    vecs[5]  = '{32'h0000007F, 64'h00000000, 3'd7, 1'b1, 64'h00000000_00000000, 3'd7, 1'b1};
    vecs[6]  = '{32'h0080006F, 64'h00000008, 3'd5, 1'b0, 64'h00000000_00000008, 3'd5, 1'b0};
    vecs[7]  = '{32'hFFDFF06F, 64'hFFFFFFFC, 3'd5, 1'b0, 64'hFFFFFFFF_FFFFFFFC, 3'd5, 1'b0};
    vecs[8]  = '{32'h003100B3, 64'h00000000, 3'd0, 1'b0, 64'h00000000_00000000, 3'd0, 1'b0};
    vecs[9]  = '{32'h0010009B, 64'h00000000, 3'd7, 1'b1, 64'h00000000_00000001, 3'd1, 1'b0};
    vecs[10] = '{32'h03F09093, 64'h0000001F, 3'd1, 1'b0, 64'h00000000_0000003F, 3'd1, 1'b0};
    vecs[11] = '{32'h03F0909B, 64'h00000000, 3'd7, 1'b1, 64'h00000000_0000001F, 3'd1, 1'b0};
    vecs[12] = '{32'h80002083, 64'hFFFFF800, 3'd1, 1'b0, 64'hFFFFFFFF_FFFFF800, 3'd1, 1'b0};
    vecs[13] = '{32'h800000B7, 64'h80000000, 3'd4, 1'b0, 64'hFFFFFFFF_80000000, 3'd4, 1'b0};
    vecs[14] = '{32'h00001017, 64'h00001000, 3'd4, 1'b0, 64'h00000000_00001000, 3'd4, 1'b0};
    vecs[15] = '{32'h41F0D093, 64'h0000001F, 3'd1, 1'b0, 64'h00000000_0000001F, 3'd1, 1'b0};
    vecs[16] = '{32'hFFF01083, 64'hFFFFFFFF, 3'd1, 1'b0, 64'hFFFFFFFF_FFFFFFFF, 3'd1, 1'b0};

    // Reset values
    step();
    step();
    chk_idle("reset");
    chk("reset_dat32", 64'(dat32), 64'd0);
    chk("reset_fmt32", 64'(fmt32), 64'd0);
    chk("reset_ill32", 64'(ill32), 64'd0);
    chk("reset_dat64", dat64, 64'd0);
    rst = 1'b0;

    // Back-to-back stream with the consumer always ready: one-cycle latency
    for (int i = 0; i < NV; i++) begin
      in_valid = 1'b1;
      data_in  = vecs[i].ins;
      step();
      chk($sformatf("s%0d_vld32", i), 64'(vld32), 64'd1);
      chk($sformatf("s%0d_rdy32", i), 64'(rdy32), 64'd1);
      chk($sformatf("s%0d_dat32", i), 64'(dat32), vecs[i].e32);
      chk($sformatf("s%0d_fmt32", i), 64'(fmt32), 64'(vecs[i].f32));
      chk($sformatf("s%0d_ill32", i), 64'(ill32), 64'(vecs[i].i32));
      chk($sformatf("s%0d_vld64", i), 64'(vld64), 64'd1);
      chk($sformatf("s%0d_dat64", i), dat64, vecs[i].e64);
      chk($sformatf("s%0d_fmt64", i), 64'(fmt64), 64'(vecs[i].f64));
      chk($sformatf("s%0d_ill64", i), 64'(ill64), 64'(vecs[i].i64));
    end
    in_valid = 1'b0;
    step();
    chk_idle("drain");

    // Backpressure: three words offered, only two fit
    out_ready = 1'b0;
    in_valid  = 1'b1;
    data_in   = vecs[0].ins;          // A
    step();
    chk("bp_a_rdy", 64'(rdy32), 64'd1);
    chk("bp_a_dat", 64'(dat32), 64'hFFFFFFFF);
    data_in = vecs[2].ins;            // B
    step();
    chk("bp_full_rdy32", 64'(rdy32), 64'd0);
    chk("bp_full_rdy64", 64'(rdy64), 64'd0);
    chk("bp_full_dat", 64'(dat32), 64'hFFFFFFFF);
    data_in = vecs[3].ins;            // C, refused while full
    step();
    chk("bp_hold_rdy", 64'(rdy32), 64'd0);
    chk("bp_hold_vld", 64'(vld32), 64'd1);
    chk("bp_hold_dat", 64'(dat32), 64'hFFFFFFFF);
    chk("bp_hold_fmt", 64'(fmt32), 64'd1);
    out_ready = 1'b1;
    step();
    chk("bp_b_dat", 64'(dat32), 64'hFFFFFFFC);
    chk("bp_b_fmt", 64'(fmt32), 64'd2);
    chk("bp_b_rdy", 64'(rdy32), 64'd1);
    step();
    chk("bp_c_dat", 64'(dat32), 64'hFFFFFFF8);
    chk("bp_c_fmt", 64'(fmt32), 64'd3);
    chk("bp_c_dat64", dat64, 64'hFFFFFFFF_FFFFFFF8);
    in_valid = 1'b0;
    step();
    chk_idle("bp_end");

    // Flush with both entries occupied and a word offered during the flush
    out_ready = 1'b0;
    in_valid  = 1'b1;
    data_in   = vecs[4].ins;
    step();
    data_in = vecs[6].ins;
    step();
    chk("fl_full_rdy", 64'(rdy32), 64'd0);
    flush   = 1'b1;
    data_in = vecs[7].ins;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    chk_idle("fl_full");
    out_ready = 1'b1;
    step();
    chk_idle("fl_full_after");

    // Flush with one entry held; the offered word would otherwise be accepted
    out_ready = 1'b0;
    in_valid  = 1'b1;
    data_in   = vecs[4].ins;
    step();
    flush   = 1'b1;
    data_in = vecs[13].ins;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    chk_idle("fl_one");
    out_ready = 1'b1;
    step();
    chk_idle("fl_one_after");

    // Reset (together with flush) while full and mid-stream
    out_ready = 1'b0;
    in_valid  = 1'b1;
    data_in   = vecs[0].ins;
    step();
    data_in = vecs[1].ins;
    step();
    rst     = 1'b1;
    flush   = 1'b1;
    data_in = vecs[4].ins;
    step();
    chk_idle("rst_mid");
    chk("rst_mid_dat32", 64'(dat32), 64'd0);
    chk("rst_mid_fmt32", 64'(fmt32), 64'd0);
    chk("rst_mid_ill32", 64'(ill32), 64'd0);
    chk("rst_mid_dat64", dat64, 64'd0);
    rst       = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    data_in   = vecs[2].ins;
    step();
    chk("rst_first_dat", 64'(dat32), 64'hFFFFFFFC);
    chk("rst_first_fmt", 64'(fmt32), 64'd2);
    data_in = vecs[5].ins;
    step();
    chk("rst_second_dat64", dat64, 64'd0);
    chk("rst_second_fmt64", 64'(fmt64), 64'd7);
    chk("rst_second_ill64", 64'(ill64), 64'd1);
    in_valid = 1'b0;
    step();
    chk_idle("rst_end");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/imm_decode_unit.md
IMM_DECODE_UNIT -- requirements
Module: imm_decode_unit

Interface
REQ-001 Parameter XLEN, default 32, immediate output width; legal values 32 and 64.
REQ-002 Parameter SHAMT_W, default 5 when XLEN=32 and 6 when XLEN=64, shift-amount field width.
REQ-003 clk_i  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_i  input  1  synchronous, active-high reset.
REQ-005 flush_i  input  1  synchronous discard of all buffered entries.
REQ-006 in_valid_i  input  1  instruction word on data_i is valid.
REQ-007 in_ready_o  output  1  block can accept a word this cycle.
REQ-008 data_i  input  32  RISC-V instruction word.
REQ-009 out_valid_o  output  1  data_o, fmt_o and illegal_o are valid.
REQ-010 out_ready_i  input  1  consumer takes the output this cycle.
REQ-011 data_o  output  XLEN  decoded immediate.
REQ-012 fmt_o  output  3  format code: 0 R, 1 I, 2 S, 3 B, 4 U, 5 J, 7 illegal.
REQ-013 illegal_o  output  1  opcode not recognised.

Function
REQ-014 Input transfer happens when in_valid_i and in_ready_o are both high; output transfer happens when out_valid_o and out_ready_i are both high.
REQ-015 Decode is combinational on data_i and is captured at input transfer; a word accepted at edge N is presented on data_o from edge N when the output register is empty or drains the same cycle, so latency is 1 cycle.
REQ-016 Storage is a 2-entry skid buffer (output register plus skid register); sustained throughput is 1 word per cycle with out_ready_i high.
REQ-017 in_ready_o is registered and equals NOT skid-full; it never depends combinationally on out_ready_i.
REQ-018 Output order equals input order; no word is dropped or duplicated except by flush_i or rst_i.
REQ-019 While out_valid_o is high and out_ready_i is low, data_o, fmt_o and illegal_o hold stable.
REQ-020 Opcodes 0000011, 0010011 and 1100111 are I-format: imm = sign-extended data_i[31:20].
REQ-021 Exception to REQ-020: opcode 0010011 with funct3 001 or 101 gives imm = zero-extended data_i[20+SHAMT_W-1:20], fmt I.
REQ-022 Opcode 0100011 is S-format: imm = sign-extended {data_i[31:25], data_i[11:7]}.
REQ-023 Opcode 1100011 is B-format: imm = sign-extended {data_i[31], data_i[7], data_i[30:25], data_i[11:8], 1'b0}.
REQ-024 Opcodes 0110111 and 0010111 are U-format: imm = sign-extended {data_i[31:12], 12'b0}.
REQ-025 Opcode 1101111 is J-format: imm = sign-extended {data_i[31], data_i[19:12], data_i[20], data_i[30:21], 1'b0}.
REQ-026 Opcode 0110011 is R-format: imm = 0.
REQ-027 Opcode 0011011 is I-format only when XLEN=64, with shamt width 5 for funct3 001/101.
REQ-028 Any other opcode gives imm = 0, fmt_o = 7 and illegal_o = 1; the word still flows through the buffer normally.
REQ-029 Sign extension is always from the format's MSB to bit XLEN-1.
REQ-030 flush_i high at edge N empties both entries; out_valid_o = 0 and in_ready_o = 1 after N; any input offered in cycle N is discarded.
REQ-031 When rst_i and flush_i are high together, rst_i takes precedence; the result is identical.
REQ-032 Simultaneous input and output transfer with the skid register empty keeps occupancy unchanged and loads the new word into the output register.

Reset
REQ-033 rst_i high at an edge sets, after that edge: out_valid_o=0, in_ready_o=1, data_o=0, fmt_o=0, illegal_o=0, and both entries empty.
REQ-034 Reset asserted mid-stream discards all buffered words; the first post-reset input is the first output.

Verification
REQ-035 XLEN=32, data_i=0xFFF00093 (addi -1) -> one cycle later data_o=0xFFFFFFFF, fmt_o=1; data_i=0x4030D093 (srai 3) -> data_o=0x00000003.
REQ-036 data_i=0xFE112E23 (sw -4) -> 0xFFFFFFFC, fmt 2; data_i=0xFE000CE3 (beq -8) -> 0xFFFFFFF8, fmt 3.
REQ-037 XLEN=64, data_i=0x123450B7 (lui) -> 0x0000000012345000, fmt 4; data_i=0x0000007F -> imm 0, fmt 7, illegal_o=1.
REQ-038 out_ready_i=0 and 3 valid words offered back to back -> 2 accepted, then in_ready_o=0; out_ready_i=1 -> words emerge in order with no loss.
REQ-039 Buffer full, flush_i pulsed for 1 cycle -> next cycle out_valid_o=0 and in_ready_o=1; the word offered during the flush never appears at the output.
REQ-040 rst_i asserted for 1 cycle mid-stream -> all outputs take reset values; subsequent stream decodes correctly from its first word.
